mdu_hilo: RTL
=============

Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers.
- Sits directly downstream of the register file and consumes its Read_data1 (rs) and Read_data2 (rt) values for MULT, MULTU, DIV and DIVU.
- Iterative radix-2 datapath: one bit per clock, shift-add for multiply, restoring algorithm for divide.
- HI/LO results go to the MFHI/MFLO writeback mux. The busy output stalls the PC/control.

Parameters:
- WIDTH, 32, operand width. HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin an operation. Sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  multiplicand / dividend, from register file Read_data1.
- rt_data  input  WIDTH  multiplier / divisor, from register file Read_data2.
- mthi  input  1  write rs_data into HI.
- mtlo  input  1  write rs_data into LO.
- hi  output  WIDTH  HI register (high product or remainder).
- lo  output  WIDTH  LO register (low product or quotient).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO receive a result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- States: IDLE -> RUN -> FIX -> IDLE.
- IDLE:
  - start=1 at edge E0: latch op and operand magnitudes, clear the accumulator, counter=0, go to RUN. busy=1 from after E0.
  - For signed ops, magnitudes are the absolute values and the result signs are recorded.
- RUN: one iteration per edge.
  - Multiply: if multiplier LSB=1, add the multiplicand into the upper accumulator half, then shift right.
  - Divide: shift the remainder left, trial-subtract the divisor, set the quotient bit if the result is non-negative.
  - The counter increments each edge. After WIDTH iterations (edges E1..E32), go to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient negative if the signs differ; remainder takes the dividend's sign.
  - Write hi/lo, set done=1 for exactly the following cycle, busy=0, return to IDLE.
- Latency: start at E0 -> hi/lo valid and done=1 after E33. The next start is accepted at E34 at the earliest, i.e. while done is high.
- Divide by zero: the algorithm runs the full latency with no trap. Result is lo=all-ones, hi=dividend (rs_data as given, signed or unsigned).
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0.
- Signed MULT 0x80000000 * 0x80000000: hi=0x40000000, lo=0. The internal product path is 2*WIDTH+1 bits to avoid magnitude overflow.
- start while busy: ignored. No queuing, and operands are not re-sampled.
- mthi/mtlo:
  - Take effect only in IDLE, at the edge, with no done pulse.
  - Ignored while busy.
  - If start and mthi/mtlo are both asserted in IDLE, start wins and the writes are dropped.
  - mthi and mtlo together write both registers.
- hi/lo hold their previous values during RUN. There are no partial results on the outputs.
- Operands are latched at E0. Changes on rs_data/rt_data afterwards have no effect.
- reset asserted mid-operation: immediate return to the reset values; no done pulse.
- op is a full decode; all four codes are valid.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- Defined:
  - For MULT/MULTU, when the remaining unshifted multiplier bits are all zero, RUN jumps to FIX on the next edge. The accumulator is aligned by shifting right by the remaining count.
  - Minimum latency: 2 edges after E0, reached when rt_data=0.
  - Divide latency is unchanged.
- Undefined: every operation takes the fixed 33 edges after E0. The early-exit logic is absent.

Test Plan:
- MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done after E33, busy high for exactly 33 cycles.
- MULT rs=0xFFFFFFFD (-3), rt=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100. DIV rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start (different operands) and mthi issued mid-RUN -> both ignored, first result intact. mtlo rs=0x1234 in IDLE -> lo=0x1234, no done.
- reset pulled low at E10 of a DIVU -> hi=lo=0, busy=0 immediately, no done. A new DIVU 9/4 then gives lo=2, hi=1.
- MDU_EARLY_TERM_EN defined, MULTU rs=5, rt=3 -> hi=0, lo=15, done within 4 edges of start. Undefined -> same result at E33.

Source files
------------

// File: rtl/mdu_hilo_if.sv
// rtl/mdu_hilo_if.sv - request/result bundle between control, register file and the HI/LO unit
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;

  modport master (
    output start, op, rs_data, rt_data, mthi, mtlo,
    input  hi, lo, busy, done
  );

  modport slave (
    input  start, op, rs_data, rt_data, mthi, mtlo,
    output hi, lo, busy, done
  );
endinterface

// File: rtl/mdu_hilo.sv
// rtl/mdu_hilo.sv - radix-2 iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional macro MDU_EARLY_TERM_EN: multiplies exit RUN once the remaining multiplier bits are zero.
module mdu_hilo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mdu_hilo_if.slave     bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam int AW = 2 * WIDTH + 1;

  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_q, neg_d;
  logic             rneg_q, rneg_d;
  logic             divz_q, divz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  // acc holds {upper product half, multiplier} or {remainder, dividend/quotient}
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_ok;
  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quo, rem;
  logic             early;

  assign rs_neg    = !bus.op[0] && bus.rs_data[WIDTH-1];
  assign rt_neg    = !bus.op[0] && bus.rt_data[WIDTH-1];
  assign rs_mag    = rs_neg ? -bus.rs_data : bus.rs_data;
  assign rt_mag    = rt_neg ? -bus.rt_data : bus.rt_data;

  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);
  assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff  = {1'b0, div_shift} - {2'b00, opa_q};
  assign div_ok    = !div_diff[WIDTH+1];

  assign prod      = neg_q ? -acc_q : acc_q;
  assign quo       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem       = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

`ifdef MDU_EARLY_TERM_EN
  logic [WIDTH-1:0] mul_rest;
  logic [CNT_W:0]   rem_cnt;
  assign mul_rest = acc_q[WIDTH-1:0] << cnt_q;
  assign rem_cnt  = (CNT_W+1)'(WIDTH) - {1'b0, cnt_q};
  assign early    = !op_q[1] && (mul_rest == '0);
`else
  assign early    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    opa_d   = opa_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    divz_d  = divz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_RUN;
          op_d    = bus.op;
          cnt_d   = '0;
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = bus.op[1] && rs_neg;
          divz_d  = bus.op[1] && (bus.rt_data == '0);
          opa_d   = bus.op[1] ? rt_mag : rs_mag;
          acc_d   = {{(WIDTH+1){1'b0}}, (bus.op[1] ? rs_mag : rt_mag)};
        end else begin
          if (bus.mthi) hi_d = bus.rs_data;
          if (bus.mtlo) lo_d = bus.rs_data;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (early) begin
`ifdef MDU_EARLY_TERM_EN
          acc_d   = acc_q >> rem_cnt;
`endif
          state_d = S_FIX;
        end else begin
          if (op_q[1])
            acc_d = {1'b0, (div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ok};
          else
            acc_d = {1'b0, mul_sum, acc_q[WIDTH-1:1]};
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        cnt_d   = '0;
        if (op_q[1]) begin
          hi_d = rem;
          lo_d = divz_q ? '1 : quo;
        end else begin
          hi_d = prod[2*WIDTH-1:WIDTH];
          lo_d = prod[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      opa_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      divz_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      opa_q   <= opa_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      divz_q  <= divz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
endmodule
